// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/flush control with register scoreboard and data-memory handshake FSM
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rs1D,
  input  logic [3:0]  rs2D,
  input  logic [3:0]  rdD,
  input  logic        validD,
  input  logic        isBranchTakenE,
  input  logic        memOpE,
  input  logic        mem_ack,
  input  logic        wbValidW,
  input  logic [3:0]  rdW,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        mem_req,
  output logic        mem_err,
  output logic [15:0] busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

  localparam logic [1:0] FLUSH_LOAD   = 2'(FLUSH_CYCLES);
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  mem_state_t  state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] busy_q, busy_d;

  logic flush, hazard, mem_busy, stall, issue;

  // Hazard looks only at registered busy: a writeback in this cycle does not unblock until next cycle.
  always_comb begin
    hazard   = validD && (((rs1D != 4'd0) && busy_q[rs1D]) ||
                          ((rs2D != 4'd0) && busy_q[rs2D]));
    mem_busy = (state_q == REQ) || (state_q == WAIT);
    flush    = isBranchTakenE || (flush_cnt_q != 2'd0);
    stall    = (hazard || mem_busy) && !flush;
    issue    = validD && !stall && !flush;
  end

  always_comb begin
    busy_d = busy_q;
    if (wbValidW && (rdW != 4'd0)) busy_d[rdW] = 1'b0;
    if (issue && (rdD != 4'd0))    busy_d[rdD] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (isBranchTakenE)            flush_cnt_d = FLUSH_LOAD;
    else if (flush_cnt_q != 2'd0)  flush_cnt_d = flush_cnt_q - 2'd1;
  end

  // An ack arriving on the timeout cycle wins, so no error is reported.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = 1'b0;
    case (state_q)
      IDLE: if (memOpE) state_d = REQ;
      REQ: begin
        state_d    = WAIT;
        wait_cnt_d = 8'd0;
      end
      WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d   = IDLE;
          mem_err_d = 1'b1;
        end
        if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 8'd0;
      mem_err_q   <= 1'b0;
      flush_cnt_q <= 2'd0;
      busy_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign stallF  = stall;
  assign stallD  = stall;
  assign flushD  = flush;
  assign flushE  = flush;
  assign mem_req = mem_busy;
  assign mem_err = mem_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl against a cycle-level reference model
module tb_pipe_ctrl;
  localparam int FLUSH_CYCLES = 2;
  localparam int MEM_TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rs1D, rs2D, rdD, rdW;
  logic        validD, isBranchTakenE, memOpE, mem_ack, wbValidW;
  logic        stallF, stallD, flushD, flushE, mem_req, mem_err;
  logic [15:0] busy;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .validD(validD),
    .isBranchTakenE(isBranchTakenE), .memOpE(memOpE), .mem_ack(mem_ack),
    .wbValidW(wbValidW), .rdW(rdW), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .mem_req(mem_req), .mem_err(mem_err), .busy(busy)
  );

  typedef struct packed {
    logic       do_reset;
    logic       vd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic       br;
    logic       mop;
    logic       ack;
    logic       wbv;
    logic [3:0] rdw;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        mreq;
    logic        merr;
    logic [15:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: pending-write flags, flush cycles left, and memory phase
  // (-1 idle, 0 request cycle, k>=1 = k-th cycle spent waiting).
  bit busy_m[16];
  int flush_left;
  int phase;
  bit err_pending;

  task automatic model_clear();
    for (int i = 0; i < 16; i++) busy_m[i] = 1'b0;
    flush_left  = 0;
    phase       = -1;
    err_pending = 1'b0;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic stim_t mk(input logic vd, input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic [3:0] rd, input logic br, input logic mop,
                               input logic ack, input logic wbv, input logic [3:0] rdw);
    stim_t s;
    s.do_reset = 1'b0;
    s.vd = vd; s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
    s.br = br; s.mop = mop; s.ack = ack; s.wbv = wbv; s.rdw = rdw;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    bit fl, act, haz, stl, iss;
    @(posedge clk);
    #1;
    cyc++;
    reset = ~s.do_reset; validD = s.vd; rs1D = s.rs1; rs2D = s.rs2; rdD = s.rd;
    isBranchTakenE = s.br; memOpE = s.mop; mem_ack = s.ack; wbValidW = s.wbv; rdW = s.rdw;
    if (s.do_reset) begin
      model_clear();
    end else begin
      fl  = s.br || (flush_left > 0);
      act = (phase >= 0);
      haz = s.vd && (((s.rs1 != 0) && busy_m[s.rs1]) || ((s.rs2 != 0) && busy_m[s.rs2]));
      stl = (haz || act) && !fl;
      iss = s.vd && !stl && !fl;
      e.stall = stl; e.flush = fl; e.mreq = act; e.merr = err_pending;
      for (int i = 0; i < 16; i++) e.busy[i] = busy_m[i];
      exp_q.push_back(e);
      if (s.wbv && (s.rdw != 0)) busy_m[s.rdw] = 1'b0;
      if (iss && (s.rd != 0))    busy_m[s.rd]  = 1'b1;
      flush_left  = s.br ? FLUSH_CYCLES : ((flush_left > 0) ? flush_left - 1 : 0);
      err_pending = 1'b0;
      if (phase < 0) begin
        if (s.mop) phase = 0;
      end else if (phase == 0) begin
        phase = 1;
      end else if (s.ack) begin
        phase = -1;
      end else if (phase == MEM_TIMEOUT) begin
        phase = -1;
        err_pending = 1'b1;
      end else begin
        phase++;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stallD",  {15'd0, stallD},  {15'd0, e.stall});
      chk("stallF",  {15'd0, stallF},  {15'd0, e.stall});
      chk("flushD",  {15'd0, flushD},  {15'd0, e.flush});
      chk("flushE",  {15'd0, flushE},  {15'd0, e.flush});
      chk("mem_req", {15'd0, mem_req}, {15'd0, e.mreq});
      chk("mem_err", {15'd0, mem_err}, {15'd0, e.merr});
      chk("busy",    busy,             e.busy);
    end
  end

  initial begin
    stim_t s, idle, rst;
    int ack_pct;
    reset = 1'b0; validD = 1'b0; rs1D = 4'd0; rs2D = 4'd0; rdD = 4'd0; isBranchTakenE = 1'b0;
    memOpE = 1'b0; mem_ack = 1'b0; wbValidW = 1'b0; rdW = 4'd0;
    model_clear();
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst  = idle;
    rst.do_reset = 1'b1;
    repeat (3) step(rst);
    step(idle);

    // RAW on r5, released the cycle after its writeback
    step(mk(1, 0, 0, 5, 0, 0, 0, 0, 0));
    repeat (3) step(mk(1, 5, 0, 0, 0, 0, 0, 0, 0));
    step(mk(1, 5, 0, 0, 0, 0, 0, 1, 5));
    step(mk(1, 5, 0, 0, 0, 0, 0, 0, 0));
    step(idle);

    // set/clear collision on r3
    step(mk(1, 0, 0, 3, 0, 0, 0, 1, 3));
    step(idle);

    // memory access acked 4 cycles after the request cycle
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    repeat (4) step(idle);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    repeat (2) step(idle);

    // memory timeout
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    repeat (20) step(idle);

    // branch over a hazard on r2, second branch extends the window
    step(mk(1, 0, 0, 2, 0, 0, 0, 0, 0));
    step(mk(1, 0, 2, 0, 1, 0, 0, 0, 0));
    step(mk(1, 0, 2, 0, 0, 0, 0, 0, 0));
    step(mk(1, 0, 2, 0, 1, 0, 0, 0, 0));
    repeat (4) step(mk(1, 0, 2, 0, 0, 0, 0, 0, 0));

    // reset while waiting with busy = 16'h00F0
    step(rst);
    for (int r = 4; r < 8; r++) step(mk(1, 0, 0, 4'(r), 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
    repeat (3) step(idle);
    step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
    step(rst);
    repeat (2) step(idle);

    for (int i = 0; i < 3000; i++) begin
      ack_pct = (((i / 200) % 2) == 0) ? 20 : 0;
      s.do_reset = ($urandom_range(0, 199) == 0);
      s.vd  = ($urandom_range(0, 9) < 7);
      s.rs1 = 4'($urandom_range(0, 7));
      s.rs2 = 4'($urandom_range(0, 7));
      s.rd  = 4'($urandom_range(0, 7));
      s.br  = ($urandom_range(0, 99) < 8);
      s.mop = ($urandom_range(0, 99) < 10);
      s.ack = ($urandom_range(0, 99) < ack_pct);
      s.wbv = ($urandom_range(0, 99) < 40);
      s.rdw = 4'($urandom_range(0, 7));
      step(s);
    end

    repeat (2) step(idle);
    @(negedge clk);
    #1;
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
